// File: rtl/wb_prog_loader.sv
// wb_prog_loader: Wishbone slave that buffers bitstream words in a FIFO and
// serialises them MSB-first onto the fabric programming port.
module wb_prog_loader #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          RST_CYCLES = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        prog_rst_o,
    output logic        prog_done_o,
    output logic        prog_we_o,
    output logic        prog_din_o,
    output logic        irq_o
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RST   = 3'd1,
        LOAD  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state, state_d;
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   shreg, bitcnt, status, rdata;
    logic [4:0]    bit_idx;
    logic [7:0]    rst_cnt;
    logic [1:0]    reg_sel;
    logic          done_req, req, wr, start, finish, data_wr;
    logic          full, empty, busy, pop, push, stall, unused;

    assign unused  = &{1'b0, wbs_sel_i, wbs_adr_i[1:0]};
    assign reg_sel = wbs_adr_i[3:2];
    assign req     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~wbs_ack_o;
    assign wr      = req & wbs_we_i;
    assign start   = wr & (reg_sel == 2'd0) & wbs_dat_i[0];
    assign finish  = wr & (reg_sel == 2'd0) & wbs_dat_i[1] & ~wbs_dat_i[0];
    assign data_wr = wr & (reg_sel == 2'd2);
    assign full    = count == CW'(FIFO_DEPTH);
    assign empty   = count == '0;
    assign busy    = (state == RST) | (state == LOAD) | (state == SHIFT);
    // A full FIFO still takes a word in the cycle that also pops one.
    assign push    = data_wr & (state != DONE) & (~full | pop);
    assign stall   = data_wr & (state != DONE) & full & ~pop;

    assign prog_rst_o  = state == RST;
    assign prog_done_o = state == DONE;

    assign status = {13'd0, state, 4'd0, 4'(count), 4'd0, state == DONE, empty, full, busy};
    assign rdata  = (reg_sel == 2'd1) ? status : (reg_sel == 2'd3) ? bitcnt : '0;

    always_comb begin
        state_d = state;
        pop     = 1'b0;
        if (start) begin
            state_d = RST;
        end else begin
            case (state)
                RST:     state_d = (rst_cnt == 8'(RST_CYCLES - 1)) ? LOAD : RST;
                LOAD: begin
                    pop     = ~empty;
                    state_d = ~empty ? SHIFT : done_req ? DONE : LOAD;
                end
                SHIFT: begin
                    pop     = (bit_idx == 5'd31) & ~empty;
                    state_d = ((bit_idx == 5'd31) & empty) ? LOAD : SHIFT;
                end
                default: state_d = state;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) fifo_mem[wr_ptr] <= wbs_dat_i;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            shreg      <= '0;
            bit_idx    <= '0;
            bitcnt     <= '0;
            rst_cnt    <= '0;
            done_req   <= 1'b0;
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
            prog_we_o  <= 1'b0;
            prog_din_o <= 1'b0;
            irq_o      <= 1'b0;
        end else begin
            state      <= state_d;
            wr_ptr     <= start ? '0 : wr_ptr + AW'(push);
            rd_ptr     <= start ? '0 : rd_ptr + AW'(pop);
            count      <= start ? '0 : count + CW'(push) - CW'(pop);
            shreg      <= pop ? fifo_mem[rd_ptr] : (state == SHIFT) ? shreg << 1 : shreg;
            bit_idx    <= pop ? '0 : bit_idx + 5'(state == SHIFT);
            // Counted on the same edge that emits the bit, so BITCNT tracks prog_we pulses.
            bitcnt     <= start ? '0 : bitcnt + 32'(state == SHIFT);
            rst_cnt    <= ((state == RST) & ~start) ? rst_cnt + 8'd1 : '0;
            done_req   <= (start | (state_d == DONE)) ? 1'b0 : (finish & busy) ? 1'b1 : done_req;
            wbs_ack_o  <= req & ~stall;
            wbs_dat_o  <= (req & ~stall & ~wbs_we_i) ? rdata : '0;
            prog_we_o  <= (state == SHIFT) & ~start;
            prog_din_o <= (state == SHIFT) & ~start & shreg[31];
            irq_o      <= (state_d == DONE) & (state != DONE);
        end
    end
endmodule

// File: tb/tb_wb_prog_loader.sv
// tb_wb_prog_loader: randomized bench checking the loader's bus map, bit stream
// and control sequencing against a transaction-level model.
module tb_wb_prog_loader;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_i;
    logic        ack;
    logic [31:0] dat_o;
    logic        prog_rst, prog_done, prog_we, prog_din, irq;

    always #5 clk = ~clk;

    wb_prog_loader dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs_stb_i  (stb),
        .wbs_cyc_i  (cyc),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (dat_i),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (dat_o),
        .prog_rst_o (prog_rst),
        .prog_done_o(prog_done),
        .prog_we_o  (prog_we),
        .prog_din_o (prog_din),
        .irq_o      (irq)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Observed port activity, sampled away from the active edge.
    bit bits[$];
    int we_runs[$];
    int rst_runs[$];
    int we_run = 0;
    int rst_run = 0;
    int irq_cnt = 0;

    always @(negedge clk) begin
        if (prog_we) begin
            bits.push_back(prog_din);
            we_run++;
        end else if (we_run != 0) begin
            we_runs.push_back(we_run);
            we_run = 0;
        end
        if (prog_rst) rst_run++;
        else if (rst_run != 0) begin
            rst_runs.push_back(rst_run);
            rst_run = 0;
        end
        if (irq) irq_cnt++;
    end

    task automatic clear_mon();
        bits.delete();
        we_runs.delete();
        rst_runs.delete();
        irq_cnt = 0;
    endtask

    // STATUS as described by the register map: busy/full/empty/done, occupancy, state.
    function automatic logic [31:0] st_exp(input int s, input int occ);
        return 32'(s * 65536 + occ * 256 + (s == 4 ? 8 : 0) + (occ == 0 ? 4 : 0)
                   + (occ == 4 ? 2 : 0) + ((s >= 1 && s <= 3) ? 1 : 0));
    endfunction

    // waits = edges until ack, or -1 if the slave never answered.
    task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] r, output int waits);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d;
        waits = 0;
        r = '0;
        do begin
            @(posedge clk); #1;
            waits++;
        end while (!ack && waits < 100);
        if (ack) r = dat_o;
        else waits = -1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d, output int waits);
        logic [31:0] r;
        wb_access(1'b1, BASE + 32'(off), d, r, waits);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] off, input logic [31:0] exp);
        logic [31:0] r;
        int waits;
        wb_access(1'b0, BASE + 32'(off), 32'h0, r, waits);
        if (waits != 1) chk({tag, "_latency"}, waits, 1);
        chk(tag, r, exp);
    endtask

    task automatic wait_rst_end();
        for (int i = 0; i < 100 && prog_rst; i++) begin
            @(posedge clk); #1;
        end
        @(negedge clk); #1;
    endtask

    logic [31:0] words[$];
    int waits_q[$];

    // START, feed `words`, FINISH, then compare the serial stream to the words MSB-first.
    task automatic stream_test(input string tag, input int maxgap);
        int w, errs;
        bit exp_bits[$];
        clear_mon();
        waits_q.delete();
        wr(4'h0, 32'h1, w);
        foreach (words[i]) begin
            wr(4'h8, words[i], w);
            waits_q.push_back(w);
            repeat ($urandom_range(0, maxgap)) @(posedge clk);
        end
        wr(4'h0, 32'h2, w);
        for (int i = 0; i < 400 && !prog_done; i++) begin
            @(posedge clk); #1;
        end
        chk({tag, "_done"}, prog_done, 1);
        repeat (2) @(posedge clk);
        #1;
        foreach (words[i]) for (int j = 31; j >= 0; j--) exp_bits.push_back(words[i][j]);
        chk({tag, "_nbits"}, bits.size(), exp_bits.size());
        errs = 0;
        foreach (exp_bits[i]) if (i >= bits.size() || bits[i] != exp_bits[i]) errs++;
        chk({tag, "_bit_errors"}, errs, 0);
        chk({tag, "_we_runs"}, we_runs.size(), 1);
        chk({tag, "_we_run_len"}, we_runs.size() > 0 ? we_runs[0] : 0, 32 * words.size());
        chk({tag, "_rst_len"}, rst_runs.size() > 0 ? rst_runs[0] : 0, 16);
        chk({tag, "_irq"}, irq_cnt, 1);
        rd_chk({tag, "_bitcnt"}, 4'hC, 32 * words.size());
        rd_chk({tag, "_status"}, 4'h4, st_exp(4, 0));
    endtask

    initial begin
        int w;
        logic [31:0] r;
        int nb;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'hF; adr = '0; dat_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", ack, 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_prog_rst", prog_rst, 0);
        chk("rst_done", prog_done, 0);
        chk("rst_we", prog_we, 0);
        chk("rst_din", prog_din, 0);
        chk("rst_irq", irq, 0);
        rst = 1'b0;
        rd_chk("idle_status", 4'h4, st_exp(0, 0));
        rd_chk("idle_bitcnt", 4'hC, 0);

        // FINISH in IDLE is ignored; words can queue; START flushes them.
        wr(4'h0, 32'h2, w);
        rd_chk("finish_idle_status", 4'h4, st_exp(0, 0));
        wr(4'h8, $urandom, w);
        rd_chk("idle_queued", 4'h4, st_exp(0, 1));
        clear_mon();
        wr(4'h0, 32'h1, w);
        chk("start_rst_at_ack", prog_rst, 1);
        rd_chk("rst_status_flushed", 4'h4, st_exp(1, 0));
        wait_rst_end();
        chk("start_rst_len", rst_runs.size() > 0 ? rst_runs[$] : 0, 16);
        rd_chk("load_status", 4'h4, st_exp(2, 0));
        repeat (10) @(posedge clk);
        rd_chk("load_stays", 4'h4, st_exp(2, 0));
        rd_chk("load_ctrl_reads0", 4'h0, 0);

        words = '{32'hA500_0001};
        stream_test("single", 0);

        // DATA in DONE is acked and discarded; bad address is never acked.
        nb = bits.size();
        wr(4'h8, $urandom, w);
        chk("done_data_ack", w, 1);
        rd_chk("done_data_status", 4'h4, st_exp(4, 0));
        rd_chk("done_data_bitcnt", 4'hC, 32);
        chk("done_no_bits", bits.size(), nb);
        wb_access(1'b1, BASE + 32'h10, 32'h1, r, w);
        chk("badaddr_noack", w, -1);
        rd_chk("badaddr_status", 4'h4, st_exp(4, 0));

        // Burst queued during RST: 5th write must stall until the first pop.
        words.delete();
        repeat (6) words.push_back($urandom);
        stream_test("burst", 0);
        for (int i = 0; i < 4; i++) chk("burst_nostall", waits_q[i], 1);
        chk("burst_5th_stalls", waits_q[4] > 1, 1);

        // START mid-word aborts the stream and restarts RST.
        clear_mon();
        wr(4'h0, 32'h1, w);
        wr(4'h8, $urandom, w);
        for (int i = 0; i < 200 && bits.size() < 10; i++) begin
            @(posedge clk); #1;
        end
        wr(4'h0, 32'h1, w);
        chk("abort_we_drop", prog_we, 0);
        chk("abort_prog_rst", prog_rst, 1);
        rd_chk("abort_bitcnt", 4'hC, 0);
        rd_chk("abort_status", 4'h4, st_exp(1, 0));
        wait_rst_end();
        chk("abort_rst_len", rst_runs.size() > 0 ? rst_runs[$] : 0, 16);
        chk("abort_we_runs", we_runs.size(), 1);
        rd_chk("abort_load_empty", 4'h4, st_exp(2, 0));
        wr(4'h0, 32'h2, w);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_finish_done", prog_done, 1);
        rd_chk("abort_finish_bitcnt", 4'hC, 0);

        for (int k = 0; k < 5; k++) begin
            words.delete();
            repeat ($urandom_range(1, 6)) words.push_back($urandom);
            stream_test("rand", 3);
        end

        // Reset mid-stream returns everything to its reset values.
        words = '{$urandom, $urandom};
        clear_mon();
        wr(4'h0, 32'h1, w);
        foreach (words[i]) wr(4'h8, words[i], w);
        for (int i = 0; i < 200 && bits.size() < 5; i++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_we", prog_we, 0);
        chk("midrst_din", prog_din, 0);
        chk("midrst_prog_rst", prog_rst, 0);
        rst = 1'b0;
        rd_chk("midrst_status", 4'h4, st_exp(0, 0));
        rd_chk("midrst_bitcnt", 4'hC, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
